// File: rtl/uart_arb_pkg.sv
// Shared types for the UART TX arbiter and its round-robin picker.
package uart_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam int DATA_W_DEF = 8;

    // Wide enough for up to 8 requesters.
    typedef logic [2:0] req_idx_t;

endpackage

// File: rtl/uart_tx_arb_rr_pick.sv
// rr_pick: combinational round-robin winner search.
// Searches upward from last+1 with wrap-around and returns the first set request.
module rr_pick
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  req_idx_t           last,
    output req_idx_t           win,
    output logic               any
);

    logic [7:0] req_ext;

    assign req_ext = 8'(req);
    assign any     = |req;

    // Walk from farthest to nearest so the nearest set bit after last wins.
    always_comb begin
        win = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            if (req_ext[3'((int'(last) + i) % NUM_REQ)]) begin
                win = 3'((int'(last) + i) % NUM_REQ);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arb.sv
// uart_tx_arb: message-granular round-robin arbiter in front of one UART TX serializer.
// Optional stall timeout enabled by defining UART_ARB_TIMEOUT_EN.
//
// state | meaning
// IDLE  | no owner; pick a winner from the valid requesters (one bubble cycle)
// BUSY  | owner g passes bytes straight through until a handshake with last
module uart_tx_arb
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                      clk100,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    input  logic [NUM_REQ-1:0]        req_last_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    output logic                      tx_valid_o,
    output logic [DATA_W-1:0]         tx_data_o,
    input  logic                      tx_ready_i,
    output logic [NUM_REQ-1:0]        gnt_o,
    output logic                      busy_o,
    output logic                      timeout_o
);

    state_t      state, state_nxt;
    req_idx_t    gnt_idx, last_gnt, win;
    logic        any_req;
    logic        sel_valid, sel_last;
    logic [DATA_W-1:0] sel_data;
    logic        hs;
    logic        release_gnt;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req  (req_valid_i),
        .last (last_gnt),
        .win  (win),
        .any  (any_req)
    );

    // Mux out the granted requester's valid/last/data.
    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (gnt_idx == 3'(k)) begin
                sel_valid = req_valid_i[k];
                sel_last  = req_last_i[k];
                sel_data  = req_data_i[k*DATA_W +: DATA_W];
            end
        end
    end

    assign hs = (state == BUSY) && sel_valid && tx_ready_i;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] stall_cnt;
    logic             stall_hit;
    logic             timeout_q;

    // Only cycles where the owner has nothing to send count as stalls.
    assign stall_hit   = (state == BUSY) && !sel_valid && (stall_cnt == CNT_W'(TIMEOUT_CYC - 1));
    assign release_gnt = (hs && sel_last) || stall_hit;
    assign timeout_o   = timeout_q;

    // Stall counter and one-cycle timeout pulse.
    always_ff @(posedge clk100) begin
        if (rst) begin
            stall_cnt <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= stall_hit;
            if (state != BUSY || hs || stall_hit) begin
                stall_cnt <= '0;
            end else if (!sel_valid) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end
`else
    assign release_gnt = hs && sel_last;
    assign timeout_o   = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk100) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req)     state_nxt = BUSY;
            BUSY:    if (release_gnt) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Grant index capture and round-robin pointer update on release.
    always_ff @(posedge clk100) begin
        if (rst) begin
            gnt_idx  <= '0;
            last_gnt <= 3'(NUM_REQ - 1);
        end else if (state == IDLE && any_req) begin
            gnt_idx <= win;
        end else if (state == BUSY && release_gnt) begin
            last_gnt <= gnt_idx;
        end
    end

    // Zero-latency passthrough and status outputs; data forced to 0 when not valid.
    always_comb begin
        busy_o      = (state == BUSY);
        tx_valid_o  = 1'b0;
        tx_data_o   = '0;
        gnt_o       = '0;
        req_ready_o = '0;
        if (state == BUSY) begin
            tx_valid_o = sel_valid;
            tx_data_o  = sel_valid ? sel_data : '0;
            for (int k = 0; k < NUM_REQ; k++) begin
                gnt_o[k]       = (gnt_idx == 3'(k));
                req_ready_o[k] = (gnt_idx == 3'(k)) && tx_ready_i;
            end
        end
    end

endmodule
